// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: show-ahead FIFO stage latch with valid/ready handshaking.
// Holds {instr, pc} entries so fetch can run ahead of a stalled decode stage.
// flush clears the buffer and overrides everything else. stall blocks only the pop.
// When the buffer is empty, the outputs present a NOP bubble.
module pipe_stage_buffer #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       PC_W      = 32,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_instr,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    input  logic                     stall,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              push;
    logic              pop;

    // in_ready and out_valid come only from registered occupancy.
    // There is no combinational path from out_ready or stall.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~stall & ~flush;

    // Pointer and occupancy bookkeeping. flush returns everything to zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage. It is written only on push and never modified afterwards.
    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    // Show-ahead head view. A NOP bubble and PC 0 are shown while empty.
    always_comb begin
        out_instr = NOP_INSTR;
        out_pc    = '0;
        if (out_valid) begin
            out_instr = instr_mem[rd_ptr];
            out_pc    = pc_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer.
// Drives one DEPTH=2 instance and one DEPTH=4 instance from the same stimulus.
// A queue-based reference model is checked against both instances on every falling edge.
module tb_pipe_stage_buffer;

    localparam logic [31:0] NOP2 = 32'h0000_0000;
    localparam logic [31:0] NOP4 = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;
    logic        stall;
    logic        flush;

    logic        in_ready2, out_valid2;
    logic [31:0] out_instr2, out_pc2;
    logic [1:0]  count2;
    logic        in_ready4, out_valid4;
    logic [31:0] out_instr4, out_pc4;
    logic [2:0]  count4;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          seen44 = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q2[$];
    ent_t        q4[$];

    always #5 Clk = ~Clk;

    pipe_stage_buffer #(.DATA_W(32), .PC_W(32), .DEPTH(2), .NOP_INSTR(NOP2)) u_dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_instr(out_instr2), .out_pc(out_pc2), .out_ready(out_ready),
        .stall(stall), .flush(flush), .count(count2)
    );

    pipe_stage_buffer #(.DATA_W(32), .PC_W(32), .DEPTH(4), .NOP_INSTR(NOP4)) u_dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_pc(in_pc), .in_ready(in_ready4), .out_valid(out_valid4),
        .out_instr(out_instr4), .out_pc(out_pc4), .out_ready(out_ready),
        .stall(stall), .flush(flush), .count(count4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO semantics expressed as queue operations.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q2.delete();
            q4.delete();
        end else if (flush) begin
            q2.delete();
            q4.delete();
        end else begin
            bit acc2, acc4;
            acc2 = in_valid && (q2.size() < 2);
            acc4 = in_valid && (q4.size() < 4);
            if (q2.size() > 0 && out_ready && !stall) void'(q2.pop_front());
            if (q4.size() > 0 && out_ready && !stall) void'(q4.pop_front());
            if (acc2) q2.push_back('{in_instr, in_pc});
            if (acc4) q4.push_back('{in_instr, in_pc});
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge Clk) begin
        check("d2_valid", 64'(out_valid2), 64'(q2.size() != 0));
        check("d2_instr", 64'(out_instr2), 64'(q2.size() != 0 ? q2[0].instr : NOP2));
        check("d2_pc",    64'(out_pc2),    64'(q2.size() != 0 ? q2[0].pc : 32'h0));
        check("d2_count", 64'(count2),     64'(q2.size()));
        check("d2_ready", 64'(in_ready2),  64'(q2.size() != 2));
        check("d4_valid", 64'(out_valid4), 64'(q4.size() != 0));
        check("d4_instr", 64'(out_instr4), 64'(q4.size() != 0 ? q4[0].instr : NOP4));
        check("d4_pc",    64'(out_pc4),    64'(q4.size() != 0 ? q4[0].pc : 32'h0));
        check("d4_count", 64'(count4),     64'(q4.size()));
        check("d4_ready", 64'(in_ready4),  64'(q4.size() != 4));
        if ((out_valid2 && out_instr2 == 32'h44) || (out_valid4 && out_instr4 == 32'h44))
            seen44 = 1'b1;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        Reset_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid2), 64'd0);
        check("rst_instr", 64'(out_instr2), 64'd0);
        check("rst_count", 64'(count2), 64'd0);
        check("rst_ready", 64'(in_ready2), 64'd1);
        check("rst_instr4", 64'(out_instr4), 64'h13);

        // First push lands on the first rising edge after reset release.
        in_valid = 1'b1; in_instr = 32'h99; in_pc = 32'h100;
        Reset_n = 1'b1;
        step();
        check("first_valid", 64'(out_valid2), 64'd1);
        check("first_instr", 64'(out_instr2), 64'h99);
        check("first_pc", 64'(out_pc2), 64'h100);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("first_drain", 64'(count2), 64'd0);

        // Streaming: each entry appears one cycle after it is pushed.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = 32'hA0 + 32'(i); in_pc = 32'(i * 4);
            step();
            check("stream_instr", 64'(out_instr2), 64'(32'hA0 + 32'(i)));
            check("stream_pc", 64'(out_pc2), 64'(i * 4));
            check("stream_count", 64'(count2), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end", 64'(count2), 64'd0);

        // Reset mid-stream after filling two entries. Reset takes effect without a clock edge.
        stall = 1'b1; in_valid = 1'b1; in_instr = 32'h71; in_pc = 32'h8;
        step();
        in_instr = 32'h72; in_pc = 32'hC;
        step();
        check("prerst_count", 64'(count2), 64'd2);
        in_valid = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid2), 64'd0);
        check("midrst_instr", 64'(out_instr2), 64'd0);
        check("midrst_count", 64'(count2), 64'd0);
        check("midrst_ready", 64'(in_ready2), 64'd1);
        check("midrst_count4", 64'(count4), 64'd0);
        step();
        Reset_n = 1'b1;
        stall = 1'b0;
        step();

        // Fill and stall.
        stall = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h11; in_pc = 32'h40;
        step();
        check("stall_c1", 64'(count2), 64'd1);
        in_instr = 32'h22; in_pc = 32'h44;
        step();
        check("stall_full_count", 64'(count2), 64'd2);
        check("stall_full_ready", 64'(in_ready2), 64'd0);
        check("stall_head", 64'(out_instr2), 64'h11);
        in_instr = 32'h33; in_pc = 32'h48;
        step();
        check("stall_reject", 64'(count2), 64'd2);
        check("stall_hold", 64'(out_instr2), 64'h11);
        stall = 1'b0;
        step();
        check("unstall_1", 64'(out_instr2), 64'h22);
        check("unstall_1c", 64'(count2), 64'd1);
        step();
        check("unstall_2", 64'(out_instr2), 64'h33);
        check("unstall_2pc", 64'(out_pc2), 64'h48);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("stall_drain2", 64'(count2), 64'd0);
        check("stall_drain4", 64'(count4), 64'd0);

        // Flush overrides stall, push and pop in the same cycle.
        stall = 1'b1;
        in_valid = 1'b1; in_instr = 32'h55; in_pc = 32'h50;
        step();
        in_instr = 32'h66; in_pc = 32'h54;
        step();
        check("preflush_count", 64'(count2), 64'd2);
        flush = 1'b1; in_instr = 32'h44; in_pc = 32'h58; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
        check("flush_count", 64'(count2), 64'd0);
        check("flush_valid", 64'(out_valid2), 64'd0);
        check("flush_instr", 64'(out_instr2), 64'd0);
        check("flush_ready", 64'(in_ready2), 64'd1);
        check("flush_count4", 64'(count4), 64'd0);
        check("flush_instr4", 64'(out_instr4), 64'h13);
        step();
        step();

        // Wrap-around: ten pushes with mostly-low random out_ready, so the buffer fills at times.
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            bit will_take;
            in_valid = 1'b1; in_instr = 32'hC0 + n; in_pc = 32'h200 + n * 4;
            out_ready = ($urandom_range(0, 3) == 0);
            will_take = (q4.size() < 4);
            step();
            if (will_take) n++;
        end
        check("wrap_pushes", 64'(n), 64'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("wrap_drain", 64'(count4), 64'd0);

        // Empty buffer with out_ready high: no underflow.
        for (int i = 0; i < 3; i++) step();
        check("underflow2", 64'(count2), 64'd0);
        check("underflow4", 64'(count4), 64'd0);
        check("underflow_valid", 64'(out_valid2), 64'd0);

        check("flushed_never_out", 64'(seen44), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline stage buffer for the 5-stage processor, replacing fixed single-register stage latches such as the IF→ID register. It holds fetched instruction words and their PC in a small show-ahead FIFO with valid/ready handshaking, so an upstream stage can keep fetching while the downstream stage is stalled. It defines flush/stall priority explicitly and presents a NOP bubble whenever it is empty.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, program-counter width
- DEPTH, 2, entry count; power of two, ≥2
- NOP_INSTR, 32'h0000_0000, value driven on out_instr when empty (DATA_W bits)

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents an entry
- in_instr  in  DATA_W  incoming instruction
- in_pc  in  PC_W  incoming PC
- in_ready  out  1  buffer can accept an entry this cycle
- out_valid  out  1  head entry valid
- out_instr  out  DATA_W  head instruction, NOP_INSTR when empty
- out_pc  out  PC_W  head PC, 0 when empty
- out_ready  in  1  downstream consumes the head this cycle
- stall  in  1  hazard hold: blocks pop only
- flush  in  1  discard all held and incoming entries
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular array of {instr, pc}. Read pointer rd_ptr and write pointer wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~stall & ~flush.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready or stall.
- out_valid = (count != 0).
- out_instr/out_pc show the entry at rd_ptr (show-ahead) when out_valid=1, otherwise NOP_INSTR and 0.
- count update: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Simultaneous push and pop while count==DEPTH cannot occur, because in_ready=0 when full.
- Push into an empty buffer with pop=0 makes the entry visible on the next cycle. There is no same-cycle bypass.
- stall=1: head is held and outputs stay stable. Pushes are still accepted while not full.
- flush=1 (synchronous):
  - next state is count=0 and rd_ptr=wr_ptr=0.
  - Any in_valid entry in that cycle is dropped.
  - flush overrides stall, push and pop.
- Reset_n=0 (asynchronous, any time, including mid-push):
  - count=0, pointers=0, so out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1.
  - Storage array contents are don't-care.
- Stored data is never modified after it is written. Pops only advance rd_ptr.

## Timing
- Latency: in_valid accepted at edge N appears on out_* after edge N (cycle N+1) if the buffer was empty.
- Throughput: one entry per cycle sustained when out_ready=1 and stall=0.
- Full → one pop at edge N → in_ready=1 in cycle N+1.
- Flush asserted in cycle N → out_valid=0 and out_instr=NOP_INSTR from cycle N+1. in_ready=1 from cycle N+1.
- Reset release: first push is accepted on the first rising edge with Reset_n=1.
- Empty with out_ready=1: no pop and no underflow; count stays 0.

## Test plan
- Reset mid-stream:
  - Stimulus: fill 2 entries, then assert Reset_n=0 between edges.
  - Response: out_valid=0, out_instr=0, count=0 and in_ready=1 immediately (before the next edge).
- Streaming:
  - Stimulus: push instr 0xA0..0xA7 with pc 0x00..0x1C back-to-back; out_ready=1, stall=0.
  - Response: out_* follows one cycle behind, in order; count never exceeds 1.
- Fill and stall (DEPTH=2):
  - Stimulus: stall=1 while pushing 0x11 then 0x22.
  - Response:
    - count=2 and in_ready=0; third push 0x33 is not accepted; out_instr stays 0x11.
    - After stall drops: 0x11, 0x22, 0x33 emerge in order.
- Flush priority:
  - Stimulus: with count=2, assert flush, stall, in_valid (0x44) and out_ready together.
  - Response: next cycle count=0, out_instr=NOP_INSTR, out_valid=0; 0x44 is never output.
- Wrap-around (DEPTH=4):
  - Stimulus: 10 pushes interleaved with random out_ready.
  - Response:
    - Output order and values exactly match input order across pointer wraps.
    - count tracks pushes−pops and stays within 0..4.
